// File: rtl/dtb_trace_ctrl.sv
// Data Trace Buffer sequencer: ring-buffer write pointer, trigger capture,
// post-trigger delay and freeze for readout.
package DTB_PKG;
  typedef enum logic [1:0] {
    trace_mode     = 2'b00,
    rw_stream_mode = 2'b01,
    r_stream_mode  = 2'b10,
    w_stream_mode  = 2'b11
  } trg_mode_e;

  typedef struct packed {
    trg_mode_e  trg_mode;
    logic [1:0] trg_num_traces;
    logic [3:0] trg_delay;
  } control_t;

  typedef struct packed {
    logic       trg_event;
    logic [4:0] event_pos;
    logic       zero;
  } status_t;

  localparam control_t CONTROL_DEFAULT = '{trg_mode: trace_mode, trg_num_traces: 2'd0, trg_delay: 4'hF};
  localparam status_t  STATUS_DEFAULT  = '0;
endpackage

module dtb_trace_ctrl #(
  parameter int unsigned TRB_WIDTH = 32,
  parameter int unsigned TRB_DEPTH = 32,
  localparam int unsigned AW = $clog2(TRB_DEPTH),
  localparam int unsigned EW = $clog2(TRB_WIDTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  DTB_PKG::control_t   control_i,
  input  logic                control_valid_i,
  input  logic                data_valid_i,
  input  logic [TRB_WIDTH-1:0] trg_i,
  output logic                write_en_o,
  output logic [AW-1:0]       write_addr_o,
  output logic [AW-1:0]       trg_addr_o,
  output logic                wrapped_o,
  output logic                done_o,
  output logic [1:0]          num_traces_o,
  output DTB_PKG::status_t    status_o
);
  import DTB_PKG::*;

  typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, STREAM} state_e;

  state_e        state, next_state;
  control_t      control;
  logic [AW-1:0] post_cnt;
  logic [AW-1:0] post_len;
  logic [EW-1:0] low_pos;
  logic          low_found;
  logic          trigger;

  // trg_delay sixteenths of the buffer depth
  assign post_len     = AW'({control.trg_delay, AW'(0)} >> 4);
  assign trigger      = (state == ARMED) && data_valid_i && (|trg_i);
  assign num_traces_o = control.trg_num_traces;

  always_comb begin
    low_pos   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < TRB_WIDTH; i++) begin
      if (trg_i[i] && !low_found) begin
        low_pos   = EW'(i);
        low_found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    write_en_o = 1'b0;
    if (control_valid_i) begin
      next_state = (control_i.trg_mode == trace_mode) ? ARMED : STREAM;
    end else begin
      case (state)
        ARMED: begin
          write_en_o = data_valid_i;
          if (trigger) next_state = (post_len == '0) ? DONE : POST;
        end
        POST: begin
          write_en_o = data_valid_i;
          if (data_valid_i && post_cnt <= AW'(1)) next_state = DONE;
        end
        STREAM:  write_en_o = data_valid_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      control      <= CONTROL_DEFAULT;
      status_o     <= STATUS_DEFAULT;
      write_addr_o <= '0;
      trg_addr_o   <= '0;
      wrapped_o    <= 1'b0;
      done_o       <= 1'b0;
      post_cnt     <= '0;
    end else begin
      state <= next_state;
      if (control_valid_i) begin
        control      <= control_i;
        status_o     <= STATUS_DEFAULT;
        write_addr_o <= '0;
        trg_addr_o   <= '0;
        wrapped_o    <= 1'b0;
        done_o       <= 1'b0;
      end else begin
        if (write_en_o) begin
          write_addr_o <= write_addr_o + AW'(1);
          if (write_addr_o == '1) wrapped_o <= 1'b1;
        end
        if (trigger) begin
          status_o.trg_event <= 1'b1;
          status_o.event_pos <= 5'(low_pos);
          trg_addr_o         <= write_addr_o;
          post_cnt           <= post_len;
        end
        if (state == POST && data_valid_i) post_cnt <= post_cnt - AW'(1);
        if (state != DONE && next_state == DONE) done_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dtb_trace_ctrl.sv
// Directed bench for dtb_trace_ctrl with hand-computed expectations (DEPTH 32, WIDTH 32).
module tb_dtb_trace_ctrl;
  import DTB_PKG::*;

  logic             clk = 1'b0;
  logic             rst_n;
  control_t         control;
  logic             control_valid;
  logic             data_valid;
  logic [31:0]      trg;
  logic             write_en;
  logic [4:0]       write_addr;
  logic [4:0]       trg_addr;
  logic             wrapped;
  logic             done;
  logic [1:0]       num_traces;
  status_t          status;

  int tests = 0;
  int fails = 0;
  int writes;
  logic       we_s;
  logic [4:0] addr_s;

  dtb_trace_ctrl #(.TRB_WIDTH(32), .TRB_DEPTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .control_i(control), .control_valid_i(control_valid),
    .data_valid_i(data_valid), .trg_i(trg), .write_en_o(write_en), .write_addr_o(write_addr),
    .trg_addr_o(trg_addr), .wrapped_o(wrapped), .done_o(done), .num_traces_o(num_traces),
    .status_o(status)
  );

  always #5 clk = ~clk;

  // One clock: drive at negedge, sample combinational write enable, then step past posedge.
  task automatic step(input logic cv, input control_t ctl, input logic dv, input logic [31:0] t);
    @(negedge clk);
    control_valid = cv; control = ctl; data_valid = dv; trg = t;
    #1;
    we_s = write_en; addr_s = write_addr;
    if (we_s) writes++;
    @(posedge clk); #1;
    control_valid = 1'b0; data_valid = 1'b0; trg = '0;
  endtask

  task automatic start(input trg_mode_e m, input logic [1:0] nt, input logic [3:0] d);
    control_t c;
    c = '{trg_mode: m, trg_num_traces: nt, trg_delay: d};
    step(1'b1, c, 1'b0, '0);
    writes = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; control_valid = 1'b0; data_valid = 1'b0; trg = '0; control = '0;
    #12;
    tests++; if ({write_addr, trg_addr, wrapped, done, num_traces, status} !== '0) begin fails++;
      $display("FAIL reset_outputs: got %h required 0", {write_addr, trg_addr, wrapped, done, num_traces, status}); end
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 32'h1);
    tests++; if (writes !== 0) begin fails++; $display("FAIL idle_writes: got %0d required 0", writes); end
    tests++; if (write_addr !== 5'd0) begin fails++; $display("FAIL idle_addr: got %0d required 0", write_addr); end
  endtask

  task automatic test_trigger_delay0();
    start(trace_mode, 2'd1, 4'h0);
    tests++; if (num_traces !== 2'd1) begin fails++; $display("FAIL num_traces: got %0d required 1", num_traces); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, (i == 2) ? 32'h0000_0050 : 32'h0);
      tests++; if (we_s !== 1'b1 || addr_s !== 5'(i)) begin fails++;
        $display("FAIL d0_write%0d: got we=%b addr=%0d required we=1 addr=%0d", i, we_s, addr_s, i); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL d0_done: got %b required 1", done); end
    tests++; if (trg_addr !== 5'd2) begin fails++; $display("FAIL d0_trg_addr: got %0d required 2", trg_addr); end
    tests++; if (status !== 7'b1_00100_0) begin fails++; $display("FAIL d0_status: got %b required 1001000", status); end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h1);
    tests++; if (writes !== 3 || write_addr !== 5'd3) begin fails++;
      $display("FAIL d0_frozen: got writes=%0d addr=%0d required 3 and 3", writes, write_addr); end
  endtask

  task automatic test_max_delay();
    start(trace_mode, 2'd0, 4'hF);
    step(1'b0, '0, 1'b1, 32'h1);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, '0, 1'b1, 32'h0);
      if (writes == 30) begin
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL dF_early_done: got %b required 0", done); end
      end
    end
    tests++; if (writes !== 31) begin fails++; $display("FAIL dF_writes: got %0d required 31", writes); end
    tests++; if (write_addr !== 5'd31 || wrapped !== 1'b0) begin fails++;
      $display("FAIL dF_ptr: got addr=%0d wrapped=%b required 31 and 0", write_addr, wrapped); end
    tests++; if (done !== 1'b1 || status !== 7'b1_00000_0 || trg_addr !== 5'd0) begin fails++;
      $display("FAIL dF_capture: got done=%b status=%b trg_addr=%0d required 1 1000000 0", done, status, trg_addr); end
  endtask

  task automatic test_wrap();
    start(trace_mode, 2'd2, 4'h8);
    for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b1, 32'h0);
    tests++; if (wrapped !== 1'b1 || write_addr !== 5'd8 || done !== 1'b0) begin fails++;
      $display("FAIL wrap_pre: got wrapped=%b addr=%0d done=%b required 1 8 0", wrapped, write_addr, done); end
    step(1'b0, '0, 1'b1, 32'h8000_0000);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, '0, 1'b1, 32'hFFFF_FFFF);
      if (writes == 57 && we_s) begin
        tests++; if (addr_s !== 5'd24) begin fails++; $display("FAIL wrap_last_addr: got %0d required 24", addr_s); end
      end
    end
    tests++; if (writes !== 57) begin fails++; $display("FAIL wrap_writes: got %0d required 57", writes); end
    tests++; if (trg_addr !== 5'd8 || status !== 7'b1_11111_0 || done !== 1'b1) begin fails++;
      $display("FAIL wrap_capture: got trg_addr=%0d status=%b done=%b required 8 1111110 1", trg_addr, status, done); end
  endtask

  task automatic test_stream();
    start(r_stream_mode, 2'd3, 4'h1);
    for (int i = 0; i < 70; i++) step(1'b0, '0, 1'b1, 32'hFFFF_FFFF);
    tests++; if (write_addr !== 5'd6 || wrapped !== 1'b1) begin fails++;
      $display("FAIL stream_ptr: got addr=%0d wrapped=%b required 6 1", write_addr, wrapped); end
    tests++; if (status !== 7'b0 || done !== 1'b0) begin fails++;
      $display("FAIL stream_status: got status=%b done=%b required 0 0", status, done); end
  endtask

  task automatic test_back_to_back();
    control_t c;
    start(trace_mode, 2'd0, 4'hF);
    step(1'b0, '0, 1'b1, 32'h0);
    step(1'b0, '0, 1'b1, 32'h0);
    step(1'b0, '0, 1'b1, 32'h4);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 32'h0);
    tests++; if (trg_addr !== 5'd2 || status !== 7'b1_00010_0) begin fails++;
      $display("FAIL b2b_pre: got trg_addr=%0d status=%b required 2 1000100", trg_addr, status); end
    c = '{trg_mode: trace_mode, trg_num_traces: 2'd0, trg_delay: 4'h2};
    step(1'b1, c, 1'b1, 32'h1);
    tests++; if (we_s !== 1'b0) begin fails++; $display("FAIL b2b_we: got %b required 0", we_s); end
    tests++; if (write_addr !== 5'd0 || trg_addr !== 5'd0 || status !== 7'b0 || done !== 1'b0) begin fails++;
      $display("FAIL b2b_clear: got addr=%0d trg_addr=%0d status=%b done=%b required 0", write_addr, trg_addr, status, done); end
    step(1'b0, '0, 1'b1, 32'h0);
    step(1'b0, '0, 1'b1, 32'h0000_0200);
    tests++; if (status !== 7'b1_01001_0 || trg_addr !== 5'd1) begin fails++;
      $display("FAIL b2b_rearmed: got status=%b trg_addr=%0d required 1010010 1", status, trg_addr); end
    step(1'b0, '0, 1'b1, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({write_addr, trg_addr, wrapped, done, num_traces, status, write_en} !== '0) begin fails++;
      $display("FAIL async_reset: got %h required 0", {write_addr, trg_addr, wrapped, done, num_traces, status, write_en}); end
    #10 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_trigger_delay0();
    test_max_delay();
    test_wrap();
    test_stream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
